// File: rtl/lfsr_8bit_checker.sv
// lfsr_8bit_checker: receive-side checker for the 8-bit XNOR LFSR (taps 7,3,2,1).
// It seeds from the first usable sample. It locks after LOCK_CNT consecutive
// correct predictions. While locked it flags and counts every out-of-sequence
// sample.
// Optional macro LFSR_CHK_STATS_EN adds sample_cnt_o, which counts the valid
// samples accepted while locked.
module lfsr_8bit_checker #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 3,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 valid_i,
    input  logic [7:0]           state_i,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
`ifdef LFSR_CHK_STATS_EN
    output logic [CNT_WIDTH-1:0] sample_cnt_o,
`endif
    output logic                 lockup_o
);

    localparam int unsigned GW = (LOCK_CNT   > 1) ? $clog2(LOCK_CNT + 1)   : 1;
    localparam int unsigned BW = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [7:0]           pred_q, pred_d;
    logic [GW-1:0]        good_q, good_d;
    logic [BW-1:0]        bad_q, bad_d;
    logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                 err_q, err_d;
    logic                 lockup_q, lockup_d;
`ifdef LFSR_CHK_STATS_EN
    logic [CNT_WIDTH-1:0] samp_q, samp_d;
`endif

    logic                 is_ff;
    logic                 match;
    logic [GW-1:0]        good_inc;
    logic [BW-1:0]        bad_inc;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ~(s[7] ^ s[3] ^ s[2] ^ s[1])};
    endfunction

    assign is_ff    = (state_i == 8'hFF);
    assign match    = (state_i == pred_q);
    assign good_inc = good_q + GW'(1);
    assign bad_inc  = bad_q + BW'(1);

    // Next-state and next-register computation; clear overrides any sample.
    always_comb begin
        fsm_d     = fsm_q;
        pred_d    = pred_q;
        good_d    = good_q;
        bad_d     = bad_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        lockup_d  = lockup_q;
`ifdef LFSR_CHK_STATS_EN
        samp_d    = samp_q;
`endif
        if (clr_i) begin
            fsm_d     = SEARCH;
            good_d    = '0;
            bad_d     = '0;
            err_cnt_d = '0;
            lockup_d  = 1'b0;
`ifdef LFSR_CHK_STATS_EN
            samp_d    = '0;
`endif
        end else if (valid_i) begin
            if (is_ff) begin
                lockup_d = 1'b1;
            end
            unique case (fsm_q)
                SEARCH: begin
                    if (!is_ff) begin
                        pred_d = lfsr_next(state_i);
                        good_d = '0;
                        fsm_d  = VERIFY;
                    end
                end
                VERIFY: begin
                    if (is_ff) begin
                        fsm_d = SEARCH;
                    end else if (match) begin
                        good_d = good_inc;
                        pred_d = lfsr_next(state_i);
                        if (good_inc == GW'(LOCK_CNT)) begin
                            fsm_d = LOCKED;
                            bad_d = '0;
                        end
                    end else begin
                        good_d = '0;
                        pred_d = lfsr_next(state_i);
                    end
                end
                LOCKED: begin
                    // Flywheel: prediction advances from itself, never from the input.
                    pred_d = lfsr_next(pred_q);
`ifdef LFSR_CHK_STATS_EN
                    if (samp_q != '1) begin
                        samp_d = samp_q + CNT_WIDTH'(1);
                    end
`endif
                    if (match && !is_ff) begin
                        bad_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                        end
                        if (bad_inc == BW'(UNLOCK_CNT)) begin
                            fsm_d = SEARCH;
                            bad_d = '0;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
                default: begin
                    fsm_d = SEARCH;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q     <= SEARCH;
            pred_q    <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            lockup_q  <= 1'b0;
`ifdef LFSR_CHK_STATS_EN
            samp_q    <= '0;
`endif
        end else begin
            fsm_q     <= fsm_d;
            pred_q    <= pred_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            lockup_q  <= lockup_d;
`ifdef LFSR_CHK_STATS_EN
            samp_q    <= samp_d;
`endif
        end
    end

    assign locked_o  = (fsm_q == LOCKED);
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
    assign lockup_o  = lockup_q;
`ifdef LFSR_CHK_STATS_EN
    assign sample_cnt_o = samp_q;
`endif

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// Scoreboard bench for lfsr_8bit_checker. It drives two instances: the default
// parameters and a small one (LOCK_CNT=2, UNLOCK_CNT=7, CNT_WIDTH=2) for saturation.
// Both instances get the same stimulus. The reference model tracks positions in
// the 255-long LFSR orbit rather than raw register values.
module tb_lfsr_8bit_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] st = 8'h00;

    logic        locked0, err0, lk0;
    logic [15:0] cnt0;
    logic        locked1, err1, lk1;
    logic [1:0]  cnt1;
`ifdef LFSR_CHK_STATS_EN
    logic [15:0] samp0;
    logic [1:0]  samp1;
`endif

    always #5 clk = ~clk;

    lfsr_8bit_checker dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid), .state_i(st),
        .locked_o(locked0), .err_o(err0), .err_cnt_o(cnt0),
`ifdef LFSR_CHK_STATS_EN
        .sample_cnt_o(samp0),
`endif
        .lockup_o(lk0)
    );

    lfsr_8bit_checker #(.LOCK_CNT(2), .UNLOCK_CNT(7), .CNT_WIDTH(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(valid), .state_i(st),
        .locked_o(locked1), .err_o(err1), .err_cnt_o(cnt1),
`ifdef LFSR_CHK_STATS_EN
        .sample_cnt_o(samp1),
`endif
        .lockup_o(lk1)
    );

    typedef struct packed {
        logic        locked;
        logic        err;
        logic        lockup;
        logic [15:0] cnt;
        logic [15:0] samp;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int errors = 0;
    int checks = 0;

    // Orbit table: seq[k] is the k-th state starting from 00, pos[] is its inverse.
    logic [7:0] seq [255];
    int         pos [256];

    int P_LOCK [2] = '{4, 2};
    int P_UNL  [2] = '{3, 7};
    int P_MAX  [2] = '{65535, 3};

    // Model state: mode 0 = hunting, 1 = verifying, 2 = locked.
    int m_mode [2];
    int m_exp  [2];
    int m_good [2];
    int m_bad  [2];
    int m_cnt  [2];
    int m_err  [2];
    int m_lk   [2];
    int m_samp [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset(input int i);
        m_mode[i] = 0; m_exp[i] = 0; m_good[i] = 0; m_bad[i] = 0;
        m_cnt[i] = 0; m_err[i] = 0; m_lk[i] = 0; m_samp[i] = 0;
    endfunction

    function automatic void model_step(input int i, input logic c, input logic v,
                                       input logic [7:0] s);
        int p;
        p = pos[s];
        if (c) begin
            model_reset(i);
            return;
        end
        m_err[i] = 0;
        if (!v) return;
        if (s == 8'hFF) m_lk[i] = 1;
        case (m_mode[i])
            0: begin
                if (p >= 0) begin
                    m_exp[i] = (p + 1) % 255;
                    m_good[i] = 0;
                    m_mode[i] = 1;
                end
            end
            1: begin
                if (p < 0) begin
                    m_mode[i] = 0;
                end else if (p == m_exp[i]) begin
                    m_good[i]++;
                    m_exp[i] = (m_exp[i] + 1) % 255;
                    if (m_good[i] == P_LOCK[i]) begin
                        m_mode[i] = 2;
                        m_bad[i] = 0;
                    end
                end else begin
                    m_good[i] = 0;
                    m_exp[i] = (p + 1) % 255;
                end
            end
            default: begin
                if (m_samp[i] < P_MAX[i]) m_samp[i]++;
                if (p == m_exp[i]) begin
                    m_bad[i] = 0;
                end else begin
                    m_err[i] = 1;
                    if (m_cnt[i] < P_MAX[i]) m_cnt[i]++;
                    m_bad[i]++;
                    if (m_bad[i] == P_UNL[i]) begin
                        m_mode[i] = 0;
                        m_bad[i] = 0;
                    end
                end
                m_exp[i] = (m_exp[i] + 1) % 255;
            end
        endcase
    endfunction

    function automatic exp_t snap(input int i);
        exp_t e;
        e.locked = (m_mode[i] == 2);
        e.err    = m_err[i][0];
        e.lockup = m_lk[i][0];
        e.cnt    = m_cnt[i][15:0];
        e.samp   = m_samp[i][15:0];
        return e;
    endfunction

    // Drive one clock cycle of stimulus and queue the expected post-edge outputs.
    task automatic cyc(input logic c, input logic v, input logic [7:0] s);
        clr = c; valid = v; st = s;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) model_reset(i);
            else model_step(i, c, v, s);
        end
        q0.push_back(snap(0));
        q1.push_back(snap(1));
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] s);
        cyc(1'b0, 1'b1, s);
    endtask

    // Monitor: compares queued expectations against the DUTs on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("d0_locked", {31'd0, locked0}, {31'd0, e.locked});
            chk("d0_err",    {31'd0, err0},    {31'd0, e.err});
            chk("d0_lockup", {31'd0, lk0},     {31'd0, e.lockup});
            chk("d0_errcnt", {16'd0, cnt0},    {16'd0, e.cnt});
`ifdef LFSR_CHK_STATS_EN
            chk("d0_samples", {16'd0, samp0},  {16'd0, e.samp});
`endif
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("d1_locked", {31'd0, locked1}, {31'd0, e.locked});
            chk("d1_err",    {31'd0, err1},    {31'd0, e.err});
            chk("d1_lockup", {31'd0, lk1},     {31'd0, e.lockup});
            chk("d1_errcnt", {30'd0, cnt1},    {16'd0, e.cnt});
`ifdef LFSR_CHK_STATS_EN
            chk("d1_samples", {30'd0, samp1},  {16'd0, e.samp});
`endif
        end
    end

    task automatic async_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_locked0", {31'd0, locked0}, 32'd0);
        chk("arst_err0",    {31'd0, err0},    32'd0);
        chk("arst_cnt0",    {16'd0, cnt0},    32'd0);
        chk("arst_lockup0", {31'd0, lk0},     32'd0);
        chk("arst_locked1", {31'd0, locked1}, 32'd0);
        chk("arst_cnt1",    {30'd0, cnt1},    32'd0);
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] s;
        int src;
        int r;

        for (int k = 0; k < 256; k++) pos[k] = -1;
        s = 8'h00;
        for (int k = 0; k < 255; k++) begin
            seq[k] = s;
            pos[s] = k;
            s = {s[6:0], ~(s[7] ^ s[3] ^ s[2] ^ s[1])};
        end

        // Reset state.
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h00);
        rst_n = 1'b1;

        // Lock on 00..0D, then a single error with flywheel recovery.
        send(8'h00); send(8'h01); send(8'h03); send(8'h06); send(8'h0D);
        send(8'h1C); send(8'h37); send(8'h6F);
        // Three wrong samples force resync on the default instance, then relock.
        send(8'hAA); send(8'h55); send(8'hAA);
        send(8'h06); send(8'h0D); send(8'h1B); send(8'h37); send(8'h6F);
        // Lockup while locked, then in hunting state, with clears.
        send(8'hFF);
        cyc(1'b1, 1'b0, 8'h00);
        send(8'hFF);
        send(8'hFF);
        cyc(1'b1, 1'b1, 8'h00);
        // Gaps while locked, then clear together with a valid sample.
        send(8'h00); send(8'h01); send(8'h03); send(8'h06); send(8'h0D);
        send(8'h1B);
        cyc(1'b0, 1'b0, 8'h00); cyc(1'b0, 1'b0, 8'h00);
        send(8'h37);
        cyc(1'b0, 1'b0, 8'h00);
        send(8'h6F);
        cyc(1'b1, 1'b1, 8'hDE);
        // Five locked-mode mismatches saturate the 2-bit counter instance.
        send(8'h00); send(8'h01); send(8'h03); send(8'h06); send(8'h0D);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        cyc(1'b0, 1'b0, 8'h00);
        // Asynchronous reset mid-stream; next sample is a fresh seed.
        send(8'h1B);
        async_reset();
        send(8'h37); send(8'h6F); send(8'hDE); send(8'hBC);

        // Randomized traffic: mostly in-orbit samples with gaps, errors, jumps and clears.
        src = $urandom_range(0, 254);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 999);
            if (r < 8) begin
                cyc(1'b1, $urandom_range(0, 1) == 1, seq[src]);
            end else if (r < 150) begin
                cyc(1'b0, 1'b0, 8'($urandom));
            end else if (r < 200) begin
                send(8'($urandom));
            end else if (r < 215) begin
                send(8'hFF);
            end else if (r < 225) begin
                src = $urandom_range(0, 254);
                send(seq[src]);
                src = (src + 1) % 255;
            end else begin
                send(seq[src]);
                src = (src + 1) % 255;
            end
        end

        cyc(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        #1;
        chk("queue_drain", q0.size() + q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_8bit_checker.md
Name: lfsr_8bit_checker

Overview:
- Receive-side companion of the team's 8-bit XNOR LFSR generator (taps 7,3,2,1). Consumes successive 8-bit LFSR states and self-synchronises to the sequence.
- Once synchronised, flags every sample that breaks the sequence and counts errors.
- Used in BIST and link checks, and to monitor the pseudo-random replacement-way stream in caches.

Parameters:
LOCK_CNT, 4, consecutive correct predictions needed to declare lock (>=1)
UNLOCK_CNT, 3, consecutive mismatches while locked that force resync (>=1)
CNT_WIDTH, 16, width of the error counter (and sample counter when enabled)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clr_i  input  1  synchronous clear of FSM, counters and sticky flags
valid_i  input  1  state_i carries a new LFSR sample this cycle
state_i  input  8  observed LFSR state
locked_o  output  1  checker is locked to the sequence
err_o  output  1  one-cycle pulse: previous accepted sample mismatched while locked
err_cnt_o  output  CNT_WIDTH  saturating count of locked-mode mismatches
lockup_o  output  1  sticky: an 8'hFF lockup state was observed

Behaviour:
- Interface: reset rst_ni, asynchronous, active-low; clock clk_i.
- Successor function: next(s) = {s[6:0], ~(s[7]^s[3]^s[2]^s[1])}.
- 8'hFF is the lockup state, because next(FF)=FF.
- Registers:
  - fsm_q in {SEARCH, VERIFY, LOCKED}
  - pred_q[7:0], the expected next sample
  - good_q, bad_q: small counters sized for LOCK_CNT and UNLOCK_CNT
  - err_cnt_q, err_q, lockup_q
- Reset values: fsm=SEARCH, pred=0, counters=0, locked_o=0, err_o=0, err_cnt_o=0, lockup_o=0.
- All outputs are registered. locked_o = (fsm_q==LOCKED).
- valid_i=0: all state holds; err_o deasserts.
- SEARCH, on valid:
  - state_i!=FF: pred<=next(state_i), good<=0, go to VERIFY.
  - state_i==FF: stay in SEARCH.
- VERIFY, on valid:
  - Match (state_i==pred_q and state_i!=FF): good+1 and pred<=next(state_i). When good+1==LOCK_CNT, go to LOCKED with bad<=0.
  - Mismatch: good<=0 and pred<=next(state_i), i.e. reseed and stay in VERIFY.
  - FF sample: go to SEARCH.
  - VERIFY never asserts err_o and never increments err_cnt.
- LOCKED, on valid:
  - pred<=next(pred_q) always (flywheel: no reseed while locked).
  - Match: bad<=0.
  - Mismatch, including FF: err_o=1 in the next cycle, err_cnt+1 saturating at all-ones, bad+1.
  - When bad+1==UNLOCK_CNT: go to SEARCH, bad<=0. locked_o falls the cycle after that sample.
- Latency: with LOCK_CNT=N, locked_o rises the cycle after the (N+1)th consecutive valid in-sequence sample (first sample seeds, N samples verify).
- lockup_q: set on any valid sample ==8'hFF in any state. Sticky until clr_i or reset.
- clr_i has highest priority and applies to the same cycle:
  - fsm<=SEARCH; good, bad, err_cnt, err_q, lockup_q <= 0.
  - A valid sample in the same cycle is ignored.
  - pred_q is don't-care.
- Saturation: err_cnt holds at 2^CNT_WIDTH-1. err_o still pulses per mismatch.
- Reset mid-operation: immediate return to the reset values; the next valid sample is treated as a seed.

Optional Feature:
- Macro: LFSR_CHK_STATS_EN
- Defined:
  - Adds output sample_cnt_o [CNT_WIDTH-1:0].
  - It is a saturating count of valid samples accepted while locked, with the sample that causes the LOCKED exit included.
  - Cleared by clr_i or reset.
- Undefined: the port and its counter do not exist, and behaviour is otherwise identical.

Test Plan:
1. Lock: LOCK_CNT=4, one valid per cycle with 00,01,03,06,0D.
   -> locked_o=1 the cycle after 0D; err_o never asserted; err_cnt_o=0.
2. Single error: locked after scenario 1, send 1C (expected 1B), then 37,6F.
   -> err_o pulses once the cycle after 1C; err_cnt_o=1; locked_o stays 1; 37 and 6F accepted without error (flywheel).
3. Resync: locked, UNLOCK_CNT=3, send three wrong samples AA,55,AA.
   -> err_cnt_o=3; locked_o=0 the cycle after the third sample; then 06,0D,1B,37,6F relocks.
4. Lockup: send FF in SEARCH, then in LOCKED.
   -> lockup_o=1 sticky; in SEARCH, fsm stays SEARCH; in LOCKED, err_o pulses and err_cnt increments; clr_i clears lockup_o.
5. Gaps and clear: locked, interleave valid_i=0 cycles between 37,6F.
   -> no errors, state held. Then assert clr_i together with valid_i.
   -> locked_o=0, err_cnt_o=0, and that sample is ignored.
6. Saturation and reset: CNT_WIDTH=2, force 5 locked-mode mismatches (UNLOCK_CNT large).
   -> err_cnt_o=3 and held; async rst_ni low mid-stream -> all outputs 0 immediately.
